ascii_operand_parser: RTL

Front-end parser for the two-digit ASCII adder. It accepts a stream of 7-bit ASCII characters, one per handshake, in the form "A+B=" or "A+B<CR>", where each operand is one or two decimal digits. It outputs the tens and units digits of both operands as zero-padded ASCII, ready for the adder's AD/AU/BD/BU inputs. Malformed input and stalled input are reported with a one-cycle error pulse.

---
 rtl/ascii_operand_parser.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ascii_operand_parser.sv
// ascii_operand_parser: parses "A+B=" / "A+B<CR>" ASCII expressions into
// zero-padded tens/units digits for the two-digit ASCII adder.
`default_nettype none

module ascii_operand_parser #(
   parameter int TIMEOUT = 1000,
   parameter int CNT_W   = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] char_in,
   input  logic       char_valid,
   output logic       char_ready,
   output logic [6:0] AD,
   output logic [6:0] AU,
   output logic [6:0] BD,
   output logic [6:0] BU,
   output logic       op_valid,
   input  logic       op_ack,
   output logic       err
);

   typedef enum logic [2:0] {
      A1   = 3'd0,
      A2   = 3'd1,
      AP   = 3'd2,
      B1   = 3'd3,
      B2   = 3'd4,
      BT   = 3'd5,
      HOLD = 3'd6
   } state_t;

   localparam logic [6:0]       ASCII_ZERO = 7'h30;
   localparam logic [CNT_W-1:0] TO_VAL     = CNT_W'(TIMEOUT);

   state_t           state, state_nx;
   logic [6:0]       ad_nx, au_nx, bd_nx, bu_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             err_nx;
   logic             bad;

   logic is_digit, is_plus, is_term, is_space, xfer;

   assign is_digit   = (char_in >= 7'h30) && (char_in <= 7'h39);
   assign is_plus    = (char_in == 7'h2B);
   assign is_term    = (char_in == 7'h3D) || (char_in == 7'h0D);
   assign is_space   = (char_in == 7'h20);
   assign char_ready = (state != HOLD);
   assign op_valid   = (state == HOLD);
   assign xfer       = char_valid && char_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= A1;
         AD    <= ASCII_ZERO;
         AU    <= ASCII_ZERO;
         BD    <= ASCII_ZERO;
         BU    <= ASCII_ZERO;
         cnt   <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_nx;
         AD    <= ad_nx;
         AU    <= au_nx;
         BD    <= bd_nx;
         BU    <= bu_nx;
         cnt   <= cnt_nx;
         err   <= err_nx;
      end
   end

   always_comb begin
      state_nx = state;
      ad_nx    = AD;
      au_nx    = AU;
      bd_nx    = BD;
      bu_nx    = BU;
      cnt_nx   = cnt;
      err_nx   = 1'b0;
      bad      = 1'b0;
      if (xfer) begin
         // A transfer always restarts the idle counter, even if it coincides with expiry.
         cnt_nx = '0;
         if (!is_space) begin
            case (state)
               A1: begin
                  if (is_digit) begin
                     au_nx    = char_in;
                     ad_nx    = ASCII_ZERO;
                     state_nx = A2;
                  end else bad = 1'b1;
               end
               A2: begin
                  if (is_digit) begin
                     ad_nx    = AU;
                     au_nx    = char_in;
                     state_nx = AP;
                  end else if (is_plus) state_nx = B1;
                  else bad = 1'b1;
               end
               AP: begin
                  if (is_plus) state_nx = B1;
                  else bad = 1'b1;
               end
               B1: begin
                  if (is_digit) begin
                     bu_nx    = char_in;
                     bd_nx    = ASCII_ZERO;
                     state_nx = B2;
                  end else bad = 1'b1;
               end
               B2: begin
                  if (is_digit) begin
                     bd_nx    = BU;
                     bu_nx    = char_in;
                     state_nx = BT;
                  end else if (is_term) state_nx = HOLD;
                  else bad = 1'b1;
               end
               BT: begin
                  if (is_term) state_nx = HOLD;
                  else bad = 1'b1;
               end
               default: begin
               end
            endcase
            if (bad) begin
               err_nx   = 1'b1;
               state_nx = A1;
            end
         end
      end else if (state == A1 || state == HOLD) begin
         cnt_nx = '0;
         if (state == HOLD && op_ack) state_nx = A1;
      end else if (TIMEOUT != 0 && cnt == TO_VAL) begin
         err_nx   = 1'b1;
         state_nx = A1;
         cnt_nx   = '0;
      end else begin
         cnt_nx = cnt + CNT_W'(1);
      end
   end

endmodule

`default_nettype wire
